ifu_fetch: RTL and testbench

Instruction fetch stage directly downstream of the PC unit. It accepts one PC at a time and issues a single-beat read on the instruction bus. It then extracts the 32-bit instruction from the 64-bit response and holds it, with its PC and fault status, until decode consumes it. Its `o_pc_ready` is the PC unit's register write enable, so the PC advances only when a fetch is accepted.

---
 rtl/ifu_fetch.sv | 120 ++++++++++++
 tb/tb_ifu_fetch.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: takes one PC at a time, issues a single-beat read,
// and holds the extracted 32-bit instruction with its PC and fault code until decode takes it.
`timescale 1ns/1ps

module ifu_fetch #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_pc_valid,
  output logic              o_pc_ready,
  input  logic              i_flush,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic [ADDR_W-1:0] o_req_addr,
  input  logic              i_rsp_valid,
  input  logic [DATA_W-1:0] i_rsp_data,
  input  logic              i_rsp_err,
  output logic              o_rsp_ready,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic [1:0]        o_fault
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } state_e;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_BUS      = 2'd2;

  state_e            state;
  state_e            state_next;
  logic              flush_pend;
  logic              flush_pend_next;
  logic [ADDR_W-1:0] pc_q;
  logic              accept;
  logic              misaligned;
  logic              load_rsp;

  // o_pc_ready doubles as the PC unit's write enable, so it must never rise under reset or flush.
  assign o_pc_ready   = !i_rst && !i_flush &&
                        ((state == IDLE) || ((state == HOLD) && i_inst_ready));
  assign accept       = o_pc_ready && i_pc_valid;
  assign misaligned   = |i_pc[1:0];
  assign load_rsp     = (state == WAIT) && i_rsp_valid && !i_flush;

  assign o_req_valid  = !i_rst && (state == REQ);
  assign o_req_addr   = {pc_q[ADDR_W-1:3], 3'b000};
  assign o_rsp_ready  = !i_rst && ((state == WAIT) || (state == DRAIN));
  assign o_inst_valid = !i_rst && (state == HOLD);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_next      = state;
    flush_pend_next = flush_pend;
    unique case (state)
      IDLE: begin
        if (accept) state_next = misaligned ? HOLD : REQ;
      end
      REQ: begin
        // The request is never withdrawn; a flush only decides where the response ends up.
        if (i_req_ready) begin
          state_next      = (flush_pend || i_flush) ? DRAIN : WAIT;
          flush_pend_next = 1'b0;
        end else if (i_flush) begin
          flush_pend_next = 1'b1;
        end
      end
      WAIT: begin
        if (i_rsp_valid)  state_next = i_flush ? IDLE : HOLD;
        else if (i_flush) state_next = DRAIN;
      end
      HOLD: begin
        if (i_flush)           state_next = IDLE;
        else if (i_inst_ready) state_next = accept ? (misaligned ? HOLD : REQ) : IDLE;
      end
      DRAIN: begin
        if (i_rsp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      pc_q       <= '0;
      o_inst     <= '0;
      o_inst_pc  <= '0;
      o_fault    <= FAULT_NONE;
    end else begin
      state      <= state_next;
      flush_pend <= flush_pend_next;
      if (accept) pc_q <= i_pc;
      if (accept && misaligned) begin
        o_inst    <= '0;
        o_inst_pc <= i_pc;
        o_fault   <= FAULT_MISALIGN;
      end else if (load_rsp) begin
        o_inst    <= pc_q[2] ? i_rsp_data[INST_W +: INST_W] : i_rsp_data[0 +: INST_W];
        o_inst_pc <= pc_q;
        o_fault   <= i_rsp_err ? FAULT_BUS : FAULT_NONE;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run scored against a
// transaction-level model (memory contents, fault rules, flush kills everything in flight).
`timescale 1ns/1ps

module tb_ifu_fetch;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [1:0]  fault;

  int n_checks = 0;
  int n_pass   = 0;

  logic bus_stall = 1'b0;
  int   rsp_delay = 0;
  bit   rand_mode = 1'b0;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  ifu_fetch dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pc        (pc),
    .i_pc_valid  (pc_valid),
    .o_pc_ready  (pc_ready),
    .i_flush     (flush),
    .o_req_valid (req_valid),
    .i_req_ready (req_ready),
    .o_req_addr  (req_addr),
    .i_rsp_valid (rsp_valid),
    .i_rsp_data  (rsp_data),
    .i_rsp_err   (rsp_err),
    .o_rsp_ready (rsp_ready),
    .o_inst_valid(inst_valid),
    .i_inst_ready(inst_ready),
    .o_inst      (inst),
    .o_inst_pc   (inst_pc),
    .o_fault     (fault)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Memory image: the instruction stored at byte address a.
  function automatic logic [31:0] inst_at(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0000_0413;
    if (a == 64'h8000_0004) return 32'h0000_0297;
    return (a[31:0] * 32'h0100_0193) ^ 32'h5bd1_e995;
  endfunction

  function automatic bit err_at(input logic [63:0] line);
    return line[5:3] == 3'b111;
  endfunction

  function automatic exp_t predict(input logic [63:0] a);
    exp_t e;
    e.pc = a;
    if (a[1:0] != 2'b00) begin
      e.inst  = 32'h0;
      e.fault = 2'd1;
    end else begin
      e.inst  = inst_at(a);
      e.fault = err_at({a[63:3], 3'b000}) ? 2'd2 : 2'd0;
    end
    return e;
  endfunction

  // Bus slave: one outstanding read, response after a programmable or random delay.
  bit          bus_hs_req, bus_hs_rsp, bus_was_rst, bus_pending;
  logic [63:0] bus_cap_addr, bus_line;
  int          bus_cnt;
  initial begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_err     = 1'b0;
    bus_pending = 1'b0;
    bus_cnt     = 0;
    forever begin
      @(negedge clk);
      bus_hs_req   = req_valid && req_ready;
      bus_hs_rsp   = rsp_valid && rsp_ready;
      bus_was_rst  = rst;
      bus_cap_addr = req_addr;
      @(posedge clk);
      #1;
      if (bus_was_rst) begin
        bus_pending = 1'b0;
        rsp_valid   = 1'b0;
      end else begin
        if (bus_hs_rsp) begin
          rsp_valid   = 1'b0;
          bus_pending = 1'b0;
        end
        if (bus_hs_req) begin
          bus_pending = 1'b1;
          bus_line    = bus_cap_addr;
          bus_cnt     = rand_mode ? int'($urandom_range(0, 3)) : rsp_delay;
        end
        if (bus_pending && !rsp_valid) begin
          if (bus_cnt == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = {inst_at(bus_line + 64'd4), inst_at(bus_line)};
            rsp_err   = err_at(bus_line);
          end else begin
            bus_cnt--;
          end
        end
      end
      req_ready = !bus_stall && (!rand_mode || ($urandom_range(0, 2) != 0));
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  int          outstanding;
  bit          req_expected, prev_req_stall, prev_hold_stall;
  logic [63:0] last_pc, prev_addr, prev_inst_pc;
  logic [31:0] prev_inst;
  logic [1:0]  prev_fault;
  initial begin
    exp_t e;
    outstanding     = 0;
    req_expected    = 1'b0;
    prev_req_stall  = 1'b0;
    prev_hold_stall = 1'b0;
    last_pc         = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        outstanding     = 0;
        req_expected    = 1'b0;
        prev_req_stall  = 1'b0;
        prev_hold_stall = 1'b0;
      end else begin
        if (prev_req_stall) begin
          check("req_valid_stable", req_valid, 1);
          check("req_addr_stable", req_addr, prev_addr);
        end
        if (prev_hold_stall) begin
          check("hold_valid_stable", inst_valid, 1);
          check("hold_inst_stable", inst, prev_inst);
          check("hold_pc_stable", inst_pc, prev_inst_pc);
          check("hold_fault_stable", fault, prev_fault);
        end
        if (req_valid && req_ready) begin
          check("one_outstanding", outstanding, 0);
          check("req_expected", req_expected, 1);
          check("req_addr", req_addr, {last_pc[63:3], 3'b000});
          outstanding++;
          req_expected = 1'b0;
        end
        if (rsp_valid && rsp_ready && outstanding > 0) outstanding--;
        if (flush) begin
          exp_q.delete();
        end else if (inst_valid && inst_ready) begin
          check("inst_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_inst", inst, e.inst);
            check("sb_inst_pc", inst_pc, e.pc);
            check("sb_fault", fault, e.fault);
          end
        end
        if (pc_valid && pc_ready) begin
          exp_q.push_back(predict(pc));
          last_pc      = pc;
          req_expected = (pc[1:0] == 2'b00);
        end
        prev_req_stall  = req_valid && !req_ready;
        prev_addr       = req_addr;
        prev_hold_stall = inst_valid && !inst_ready && !flush;
        prev_inst       = inst;
        prev_inst_pc    = inst_pc;
        prev_fault      = fault;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic accept(input logic [63:0] a);
    pc       = a;
    pc_valid = 1'b1;
    settle();
    check("accept_pc_ready", pc_ready, 1);
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic wait_inst(input int budget);
    int n;
    n = 0;
    settle();
    while (!inst_valid && n < budget) begin
      tick();
      settle();
      n++;
    end
    check("inst_valid_timeout", inst_valid, 1);
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_acc;
    bit acc;
    rst        = 1'b1;
    pc         = '0;
    pc_valid   = 1'b0;
    flush      = 1'b0;
    inst_ready = 1'b0;
    repeat (3) tick();
    settle();
    check("rst_pc_ready", pc_ready, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_rsp_ready", rsp_ready, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;
    settle();
    check("post_rst_pc_ready", pc_ready, 1);

    // Aligned fetch with a zero-wait bus: instruction visible three cycles after accept.
    tick();
    pc       = 64'h8000_0000;
    pc_valid = 1'b1;
    settle();
    check("t0_pc_ready", pc_ready, 1);
    tick();
    pc_valid = 1'b0;
    settle();
    check("t1_req_valid", req_valid, 1);
    check("t1_req_addr", req_addr, 64'h8000_0000);
    check("t1_inst_valid", inst_valid, 0);
    tick();
    settle();
    check("t2_rsp_ready", rsp_ready, 1);
    check("t2_inst_valid", inst_valid, 0);
    tick();
    settle();
    check("t3_inst_valid", inst_valid, 1);
    check("t3_inst", inst, 64'h0000_0413);
    check("t3_inst_pc", inst_pc, 64'h8000_0000);
    check("t3_fault", fault, 0);
    inst_ready = 1'b1;
    pc         = 64'h8000_0004;
    pc_valid   = 1'b1;
    settle();
    check("b2b_pc_ready", pc_ready, 1);
    tick();
    pc_valid   = 1'b0;
    inst_ready = 1'b0;
    settle();
    check("b2b_inst_valid_drop", inst_valid, 0);
    check("b2b_req_valid", req_valid, 1);
    tick();
    tick();
    settle();
    check("hi_inst_valid", inst_valid, 1);
    check("hi_inst", inst, 64'h0000_0297);
    check("hi_inst_pc", inst_pc, 64'h8000_0004);
    check("hi_fault", fault, 0);

    // Decode backpressure in HOLD, then bus backpressure in REQ.
    bus_stall = 1'b1;
    pc        = 64'h8000_0008;
    pc_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      settle();
      check("bp_hold_valid", inst_valid, 1);
      check("bp_hold_inst", inst, 64'h0000_0297);
      check("bp_pc_ready", pc_ready, 0);
    end
    inst_ready = 1'b1;
    settle();
    check("bp_release_pc_ready", pc_ready, 1);
    tick();
    inst_ready = 1'b0;
    pc_valid   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_req_valid", req_valid, 1);
      check("bp_req_addr", req_addr, 64'h8000_0008);
      tick();
    end
    bus_stall = 1'b0;
    wait_inst(8);
    check("bp_inst", inst, 64'(inst_at(64'h8000_0008)));
    check("bp_inst_pc", inst_pc, 64'h8000_0008);
    consume();

    // Faults: misaligned PC skips the bus; an erroring response reports a bus fault.
    accept(64'h8000_0002);
    settle();
    check("mis_inst_valid", inst_valid, 1);
    check("mis_fault", fault, 1);
    check("mis_inst", inst, 0);
    check("mis_inst_pc", inst_pc, 64'h8000_0002);
    check("mis_no_req", req_valid, 0);
    consume();
    accept(64'h8000_0038);
    wait_inst(8);
    check("err_fault", fault, 2);
    check("err_inst", inst, 64'(inst_at(64'h8000_0038)));
    consume();

    // Flush in WAIT with the response two cycles later: discarded in DRAIN.
    rsp_delay = 2;
    accept(64'h8000_0100);
    tick();
    flush = 1'b1;
    settle();
    check("fw_wait_rsp_ready", rsp_ready, 1);
    tick();
    flush     = 1'b0;
    rsp_delay = 0;
    settle();
    check("fw_drain_rsp_ready", rsp_ready, 1);
    check("fw_drain_inst_valid", inst_valid, 0);
    check("fw_drain_pc_ready", pc_ready, 0);
    tick();
    settle();
    check("fw_rsp_inst_valid", inst_valid, 0);
    tick();
    settle();
    check("fw_idle_pc_ready", pc_ready, 1);
    check("fw_idle_inst_valid", inst_valid, 0);
    accept(64'h8000_1000);
    wait_inst(8);
    check("fw_next_inst", inst, 64'(inst_at(64'h8000_1000)));
    check("fw_next_inst_pc", inst_pc, 64'h8000_1000);
    check("fw_next_fault", fault, 0);
    consume();

    // Flush while the request is stalled: request persists, then one response is drained.
    bus_stall = 1'b1;
    accept(64'h8000_0200);
    flush = 1'b1;
    settle();
    check("fr_req_valid_0", req_valid, 1);
    tick();
    flush = 1'b0;
    settle();
    check("fr_req_valid_1", req_valid, 1);
    check("fr_req_addr_1", req_addr, 64'h8000_0200);
    tick();
    settle();
    check("fr_req_valid_2", req_valid, 1);
    bus_stall = 1'b0;
    tick();
    settle();
    check("fr_req_valid_3", req_valid, 1);
    tick();
    settle();
    check("fr_drain_req_valid", req_valid, 0);
    check("fr_drain_rsp_ready", rsp_ready, 1);
    check("fr_drain_inst_valid", inst_valid, 0);
    tick();
    settle();
    check("fr_idle_pc_ready", pc_ready, 1);
    check("fr_idle_inst_valid", inst_valid, 0);
    accept(64'h8000_0300);
    wait_inst(8);
    check("fr_next_inst", inst, 64'(inst_at(64'h8000_0300)));
    consume();

    // Flush together with decode ready in HOLD: no back-to-back accept.
    accept(64'h8000_0400);
    wait_inst(8);
    flush      = 1'b1;
    inst_ready = 1'b1;
    pc         = 64'h8000_0500;
    pc_valid   = 1'b1;
    settle();
    check("fh_pc_ready", pc_ready, 0);
    tick();
    flush      = 1'b0;
    inst_ready = 1'b0;
    pc_valid   = 1'b0;
    settle();
    check("fh_inst_valid", inst_valid, 0);
    check("fh_req_valid", req_valid, 0);
    check("fh_idle_pc_ready", pc_ready, 1);

    // Reset during WAIT.
    rsp_delay = 3;
    accept(64'h8000_0600);
    tick();
    rst = 1'b1;
    settle();
    check("rw_rsp_ready", rsp_ready, 0);
    tick();
    settle();
    check("rw_req_valid", req_valid, 0);
    check("rw_rsp_ready2", rsp_ready, 0);
    check("rw_inst_valid", inst_valid, 0);
    check("rw_pc_ready", pc_ready, 0);
    check("rw_inst", inst, 0);
    check("rw_inst_pc", inst_pc, 0);
    check("rw_fault", fault, 0);
    rst       = 1'b0;
    rsp_delay = 0;
    settle();
    check("rw_post_pc_ready", pc_ready, 1);

    // Throughput: decode always ready, PC always valid, zero-wait bus.
    pc         = 64'h8000_0800;
    pc_valid   = 1'b1;
    inst_ready = 1'b1;
    n_acc      = 0;
    for (int i = 0; i < 30; i++) begin
      settle();
      acc = pc_ready && pc_valid;
      if (acc) n_acc++;
      tick();
      if (acc) pc = pc + 64'd4;
    end
    check("throughput_accepts", n_acc, 10);
    pc_valid = 1'b0;
    repeat (5) tick();

    // Randomized traffic scored by the monitor.
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst        = ($urandom_range(0, 299) == 0);
      pc_valid   = ($urandom_range(0, 9) < 7);
      pc         = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
      if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      inst_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 19) == 0);
    end
    tick();
    rst        = 1'b0;
    flush      = 1'b0;
    pc_valid   = 1'b0;
    inst_ready = 1'b1;
    rand_mode  = 1'b0;
    repeat (20) tick();
    settle();
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
